cpu6_memarb: RTL
================

CPU6_MEMARB -- requirements
Module: cpu6_memarb

Interface
REQ-001 The block SHALL have parameter XLEN, default `CPU6_XLEN (32), giving the address and data width.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous, active-low reset: asserted when 0.
REQ-004 The block SHALL have port if_req, input, 1, instruction-fetch request, held until if_valid.
REQ-005 The block SHALL have port if_addr, input, XLEN, fetch address, stable while if_req is high.
REQ-006 The block SHALL have port if_rdata, output, XLEN, fetched instruction.
REQ-007 The block SHALL have port if_valid, output, 1, one-cycle pulse: fetch complete.
REQ-008 The block SHALL have port d_req, input, 1, data request, held until d_valid.
REQ-009 The block SHALL have port d_we, input, 1, data write enable.
REQ-010 The block SHALL have port d_addr, input, XLEN, data address.
REQ-011 The block SHALL have port d_wdata, input, XLEN, store data; d_we, d_addr and d_wdata are stable while d_req is high.
REQ-012 The block SHALL have port d_rdata, output, XLEN, load data.
REQ-013 The block SHALL have port d_valid, output, 1, one-cycle pulse: data access complete.
REQ-014 The block SHALL have port mem_req, output, 1, request to the shared memory port.
REQ-015 The block SHALL have port mem_we, output, 1, memory write enable.
REQ-016 The block SHALL have port mem_addr, output, XLEN, memory address.
REQ-017 The block SHALL have port mem_wdata, output, XLEN, memory write data.
REQ-018 The block SHALL have port mem_ready, input, 1, memory completes the access held on mem_req this cycle.
REQ-019 The block SHALL have port mem_rdata, input, XLEN, read data, valid when mem_ready is high.
REQ-020 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-021 The block SHALL implement a three-state FSM: IDLE, IF_BUSY and D_BUSY.
REQ-022 In IDLE, an eligible request SHALL be granted: register the address, we and wdata to the mem_* outputs and enter IF_BUSY or D_BUSY, so that mem_req goes high the next cycle.
REQ-023 In IF_BUSY or D_BUSY, mem_req SHALL stay high with mem_* outputs constant until a cycle with mem_ready=1; a fetch grant SHALL drive mem_we=0.
REQ-024 On the cycle with mem_ready=1, the block SHALL register mem_rdata into the owner's rdata, pulse the owner's valid on the next cycle, drop mem_req on the next cycle, and return to IDLE.
REQ-025 Minimum latency SHALL be request in IDLE at cycle N, mem_req at N+1, and valid at N+2 when mem_ready=1 at N+1.
REQ-026 A requester whose valid is high in the current cycle SHALL be ineligible for arbitration in that cycle, so that a held req is never re-granted.
REQ-027 When both requests are eligible, the grant SHALL alternate round-robin, going to the requester not granted last; the last-grant flag resets to fetch, so data wins the first tie.
REQ-028 For d_we=1, the block SHALL pulse d_valid and leave d_rdata unchanged.
REQ-029 The block SHALL never pulse if_valid and d_valid in the same cycle, and SHALL never assert mem_req in IDLE.
REQ-030 Requests that change or drop before their valid pulse SHALL be a protocol violation; the block need not detect them.
REQ-031 if_rdata and d_rdata SHALL hold their last value until the next completion for their owner.

Reset
REQ-032 While reset=0, the block SHALL immediately set state to IDLE, drive mem_req, mem_we, if_valid, d_valid and busy to 0, zero mem_addr, mem_wdata, if_rdata and d_rdata, and set the last-grant flag to fetch.
REQ-033 A reset during IF_BUSY or D_BUSY SHALL abandon the access, produce no valid pulse, and restart arbitration from IDLE after release.

Configuration
REQ-034 With CPU6_MEMARB_DPRIO_EN defined, data SHALL always win a tie (fixed priority) and the last-grant flag SHALL be removed.
REQ-035 Without CPU6_MEMARB_DPRIO_EN defined, the block SHALL use the round-robin arbitration of REQ-027.

Verification
REQ-036 The bench SHALL cover reset release, then if_req=1 with if_addr=0x100 and mem_ready=1 on the first mem_req cycle -> mem_addr=0x100 and mem_we=0 at N+1, and if_valid=1 with if_rdata=mem_rdata at N+2.
REQ-037 The bench SHALL cover a store with d_addr=0x2000, d_wdata=0xDEADBEEF and mem_ready delayed 3 cycles -> mem_req high for 4 cycles with fixed outputs, then one d_valid pulse and d_rdata unchanged.
REQ-038 The bench SHALL cover if_req and d_req both held high for 4 transactions -> grant order D, I, D, I; with CPU6_MEMARB_DPRIO_EN defined -> data first every tie.
REQ-039 The bench SHALL cover reset pulled low during D_BUSY -> mem_req=0 at once, no d_valid, and after release a held d_req is re-granted and completes.
REQ-040 The bench SHALL cover if_req held high across its if_valid cycle while d_req is idle -> no second fetch grant in the valid cycle.

Source files
------------

// File: rtl/cpu6_memarb.sv
// cpu6_memarb -- two-master arbiter for a single shared memory port.
//
// An instruction-fetch master (if_*) and a data master (d_*) each hold a
// request until their one-cycle valid pulse. The arbiter grants one of them
// from IDLE, registers the access onto mem_*, holds it until mem_ready, then
// returns the read data and pulses the owner's valid.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   if_req/if_addr        fetch request in; if_rdata/if_valid fetch result out
//   d_req/d_we/d_addr/d_wdata  data request in; d_rdata/d_valid result out
//   mem_req/mem_we/mem_addr/mem_wdata  shared memory request out
//   mem_ready/mem_rdata   memory completion in
//   busy                  high while an access is in flight (state != IDLE)
//
// Configuration macro: CPU6_MEMARB_DPRIO_EN
//   undefined (default): round-robin between the two masters on a tie
//   defined            : data always wins a tie, no last-grant state
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module cpu6_memarb #(
  parameter int XLEN = `CPU6_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_t;

  state_t state;
  logic   if_elig, d_elig;
  logic   grant_d, grant_i;

  // A master in its valid cycle still holds req; masking it here keeps the
  // completed request from being granted a second time.
  assign if_elig = if_req && !if_valid;
  assign d_elig  = d_req  && !d_valid;

`ifdef CPU6_MEMARB_DPRIO_EN
  assign grant_d = d_elig;
`else
  logic last_d;  // 1: data was granted most recently, 0: fetch

  // On a tie, the master not granted last wins.
  assign grant_d = d_elig && (!if_elig || !last_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (state == IDLE) begin
      if (grant_d)      last_d <= 1'b1;
      else if (if_elig) last_d <= 1'b0;
    end
  end
`endif

  assign grant_i = if_elig && !grant_d;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= D_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (grant_i) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
          end
        end
        IF_BUSY: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        D_BUSY: begin
          if (mem_ready) begin
            // Stores complete without disturbing the last load result.
            if (!mem_we) d_rdata <= mem_rdata;
            d_valid <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
